// File: rtl/mult_pkg.sv
// Shared definitions for the multicycle multiply/divide units.
// Holds the FSM state encoding and the default operand width.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand,
// followed by an arithmetic right shift of {ACC, Q, q_1}.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH:0]   acc,
  input  logic        [WIDTH-1:0] q,
  input  logic                    q_1,
  input  logic signed [WIDTH-1:0] m,
  output logic signed [WIDTH:0]   acc_nxt,
  output logic        [WIDTH-1:0] q_nxt,
  output logic                    q_1_nxt
);

  logic signed [WIDTH:0] m_ext;
  logic signed [WIDTH:0] sum;

  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
    // ACC sign bit is replicated; the bit shifted out of ACC enters Q.
    acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt   = {sum[0], q[WIDTH-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/booth_mult.sv
// Multicycle signed multiplier (radix-2 Booth, one step per clock).
// Launches on mult_control in IDLE, pulses mult_end when hi_out/lo_out update.
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             mult_control,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_end,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mult_state_e state, state_nxt;

  logic signed [WIDTH:0]   acc;
  logic        [WIDTH-1:0] q;
  logic                    q_1;
  logic signed [WIDTH-1:0] m;
  logic        [CNT_W-1:0] cnt;

  logic signed [WIDTH:0]   acc_nxt;
  logic        [WIDTH-1:0] q_nxt;
  logic                    q_1_nxt;
  logic                    last_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .q       (q),
    .q_1     (q_1),
    .m       (m),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

  assign last_step = (cnt == LAST_STEP);

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mult_control) state_nxt = RUN;
      RUN:     if (last_step)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status comes straight from the state register: no input-to-output path.
  assign mult_end = (state == DONE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      acc    <= '0;
      q      <= '0;
      q_1    <= 1'b0;
      m      <= '0;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_control) begin
            m   <= a_in;
            acc <= '0;
            q   <= b_in;
            q_1 <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          q_1 <= q_1_nxt;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            hi_out <= acc_nxt[WIDTH-1:0];
            lo_out <= q_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed table, corner sequences,
// and randomized operands against a plain signed-multiply model.
module tb_booth_mult;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        mult_control = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        mult_end;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_prod = '0;

  booth_mult #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .mult_control (mult_control),
    .a_in         (a_in),
    .b_in         (b_in),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .mult_end     (mult_end),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Starts one multiply, scrambles the operand inputs, waits for mult_end,
  // and checks latency, hold of the old result, and the return to IDLE.
  task automatic do_mult(input string nm, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] prod);
    int lat;
    @(negedge clk);
    a_in = a;
    b_in = b;
    mult_control = 1'b1;
    @(posedge clk); #1;
    mult_control = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    chk({nm, "_busy_start"}, 64'(busy), 64'd1);
    lat = 0;
    while (!mult_end && lat < 40) begin
      if (lat == 5) chk({nm, "_hold_prev"}, {hi_out, lo_out}, last_prod);
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd32);
    prod = {hi_out, lo_out};
    @(posedge clk); #1;
    chk({nm, "_end_drop"}, 64'(mult_end), 64'd0);
    chk({nm, "_busy_drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] prod;
    logic [31:0] ra, rb;
    int pulses, pulse_cyc;
    logic [63:0] pulse_val;

    vecs[0] = '{32'd3,          32'd4,          32'h00000000, 32'h0000000C};
    vecs[1] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[2] = '{32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000};
    vecs[3] = '{32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF, 32'h00000001};
    vecs[4] = '{32'h80000000,   32'h7FFFFFFF,   32'hC0000000, 32'h80000000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_prod", {hi_out, lo_out}, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_end", 64'(mult_end), 64'd0);
    @(negedge clk);
    reset_in = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, prod);
      chk($sformatf("vec%0d_prod", i), prod, {vecs[i].hi, vecs[i].lo});
      last_prod = {vecs[i].hi, vecs[i].lo};
    end

    // Restart attempt mid-run must be ignored, operands changed mid-run too.
    @(negedge clk);
    a_in = 32'd5;
    b_in = 32'd6;
    mult_control = 1'b1;
    @(posedge clk); #1;
    mult_control = 1'b0;
    pulses = 0;
    pulse_cyc = -1;
    pulse_val = '0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (mult_end) begin
        pulses++;
        if (pulse_cyc < 0) begin
          pulse_cyc = c;
          pulse_val = {hi_out, lo_out};
        end
      end
      if (c == 9) begin
        mult_control = 1'b1;
        a_in = 32'd7;
        b_in = 32'd7;
      end else if (c == 10) begin
        mult_control = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
      end
    end
    chk("restart_pulses", 64'(pulses), 64'd1);
    chk("restart_cycle", 64'(pulse_cyc), 64'd32);
    chk("restart_prod", pulse_val, 64'h0000_0000_0000_001E);
    last_prod = 64'h1E;

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a_in = 32'd2;
    b_in = 32'd9;
    mult_control = 1'b1;
    @(posedge clk); #1;
    mult_control = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset_in = 1'b0;
    #1;
    chk("midrst_prod", {hi_out, lo_out}, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_end", 64'(mult_end), 64'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mult_end || busy) pulses++;
    end
    @(negedge clk);
    reset_in = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (mult_end || busy) pulses++;
    end
    chk("midrst_quiet", 64'(pulses), 64'd0);
    last_prod = '0;
    do_mult("after_rst", 32'd2, 32'd9, prod);
    chk("after_rst_prod", prod, 64'h12);
    last_prod = 64'h12;

    // Randomized operands, biased toward the extremes.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = 32'h80000000;
        2: ra = 32'h7FFFFFFF;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      do_mult($sformatf("rnd%0d", i), ra, rb, prod);
      chk($sformatf("rnd%0d_prod", i), prod, model(ra, rb));
      last_prod = model(ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult.md
# booth_mult

Multicycle signed multiplier for the MIPS datapath; executes `mult` using radix-2 Booth recoding, one partial-product step per clock. Sits directly downstream of the control unit. It launches on the control unit's `mult_control` strobe, takes operands from the A/B registers, and returns `mult_end` to the control unit. The 64-bit product is presented on `hi_out`/`lo_out` for capture by the HI/LO registers.

## Interface
- `WIDTH`, 32, operand width; product is 2*WIDTH bits
- `clk`  in  1  system clock, all state on rising edge
- `reset_in`  in  1  asynchronous, active-low reset
- `mult_control`  in  1  start strobe from control unit; sampled only in IDLE
- `a_in`  in  WIDTH  multiplicand (signed, two's complement), from A register
- `b_in`  in  WIDTH  multiplier (signed), from B register
- `hi_out`  out  WIDTH  upper half of last completed product
- `lo_out`  out  WIDTH  lower half of last completed product
- `mult_end`  out  1  high for exactly one cycle when a new product is on `hi_out`/`lo_out`
- `busy`  out  1  high in RUN and DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `mult_control`=1 at an edge:
  - latch `a_in` into multiplicand register M.
  - Load accumulator ACC (WIDTH+1 bits) = 0, Q = `b_in`, q_1 = 0, counter = 0.
  - Go to RUN.
- IDLE, `mult_control`=0: hold.
- RUN step on every edge:
  - Inspect {Q[0], q_1}. 01 gives ACC = ACC + sext(M); 10 gives ACC = ACC - sext(M); 00 and 11 leave ACC unchanged.
  - Then arithmetic right shift of {ACC, Q, q_1} by 1, with ACC[WIDTH] replicated.
  - counter += 1.
- RUN exit: on the step edge where counter == WIDTH-1:
  - `hi_out` = ACC[WIDTH-1:0] and `lo_out` = Q, both taken after that step.
  - Go to DONE.
- DONE: `mult_end`=1. Next edge goes unconditionally to IDLE.
- `mult_control` is ignored in RUN and DONE. The operands are not re-sampled and the running operation is not restarted.
- `a_in`/`b_in` may change after the start edge without affecting the result.
- ACC is WIDTH+1 bits so that M = -2^(WIDTH-1) cannot overflow. The result is exact for all operand pairs, including the most negative value squared.
- `hi_out`/`lo_out` hold the previous result until the next RUN exit; they are never cleared by a new start.
- Reset (any time, including mid-RUN):
  - state goes to IDLE; ACC, Q, q_1, M, counter, `hi_out`, `lo_out` all go to 0.
  - `mult_end`=0, `busy`=0.
  - The in-flight operation is discarded.

## Timing
- Start edge t0. RUN steps occur on edges t1..tWIDTH; for WIDTH=32 that is 32 steps.
- Result registered at edge tWIDTH. `mult_end` is high between tWIDTH and tWIDTH+1, and the FSM is back in IDLE after tWIDTH+1.
- Start-to-`mult_end` latency is WIDTH cycles. A new start is accepted no earlier than edge tWIDTH+2.
- `mult_end` and `busy` are decoded from the state register, so they are glitch-free, have no combinational input-to-output path, and stay stable for the full cycle.
- `hi_out`/`lo_out` are valid whenever `mult_end`=1. The control unit writes HI/LO in the same cycle.

## Structure
- Shared package `mult_pkg`: state enum (IDLE, RUN, DONE), default `WIDTH`, and counter width $clog2(WIDTH). The divider block reuses this package.
- One sub-module, `booth_step`: purely combinational. Input {ACC, Q, q_1, M}; output the next {ACC, Q, q_1} (add/sub plus arithmetic shift).
- The top level holds only the FSM, the counter, the registers, and the output registers.

## Test plan
- a=3, b=4 -> after 32 cycles `mult_end` pulses once; hi=0x00000000, lo=0x0000000C; `busy` drops the next cycle.
- a=0xFFFFFFFF (-1), b=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000 (ACC extension check).
- a=0x7FFFFFFF, b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- Start a=5, b=6. Pulse `mult_control` again at cycle 10 with a=7, b=7, and change a_in/b_in mid-run. Required: a single `mult_end` at cycle 32 with lo=0x0000001E.
- Start a=2, b=9, then assert reset_in low at cycle 15. Required: outputs 0 and IDLE immediately, with no `mult_end`. After release, a new start of 2*9 yields lo=0x00000012 after 32 cycles.
